tb_mem_ctrl: RTL and testbench
==============================

Name: tb_mem_ctrl

Overview:
- Sequences the survivor-decision memory for the Viterbi traceback unit.
- Writes the 8-bit ACS decision vectors into two external single-port RAM banks in ping-pong fashion.
- Reads the opposite bank backwards, one entry per written entry.
- Drives the traceback unit's enable, selection and decision-data inputs, cycle-aligned with RAM read latency.
- Sits between the ACS array and the traceback unit; decoded-bit order reversal (LIFO) is out of scope.

Parameters:
- DEPTH, 1024: entries per bank (one traceback block); power of two, >= 4.
- AW, 10: address width, equal to log2(DEPTH).
- DW, 8: decision vector width (one bit per trellis state).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear; returns to IDLE, same values as reset.
- acs_valid  in  1  acs_dec valid this cycle.
- acs_dec  in  DW  decision vector from ACS.
- we_a, we_b  out  1  bank write enables.
- addr_a, addr_b  out  AW  bank addresses.
- wdata  out  DW  write data, shared by both banks.
- rdata_a, rdata_b  in  DW  bank read data, synchronous read, 1-cycle latency.
- tb_d0, tb_d1  out  DW  decision data to traceback (d_in_0, d_in_1); both carry the read-bank data.
- tb_enable  out  1  traceback enable.
- tb_selection  out  1  0 = training segment, 1 = decode segment.
- err_gap  out  1  sticky: acs_valid was low during RUN.

Behaviour:
- Reset / clear values: all outputs 0, state IDLE, wr_addr 0, wr_bank A.
- Address, write-enable and wdata outputs are registered: acs_valid at cycle T gives we/addr/wdata at T+1.
- FSM states:
  - IDLE -> FILL on first acs_valid.
  - FILL: write only; no reads; tb_enable 0.
  - FILL -> RUN when wr_addr wraps DEPTH-1 -> 0.
  - RUN remains until clear or reset.
- Write side: on acs_valid, write bank wr_bank at wr_addr, then wr_addr++. On the wrap DEPTH-1 -> 0, wr_bank toggles.
- Read side (RUN only): rd_addr = DEPTH-1-wr_addr, applied to bank ~wr_bank in the same cycle as the write. The read bank's we stays 0.
- Segments:
  - tb_selection = 1 when rd_addr < DEPTH/2 (decode segment), else 0 (training segment).
  - The 1->0 edge of tb_selection marks the start of a new block; this is the traceback state-reset condition.
- Alignment:
  - Control is issued at T and the address is registered at T+1.
  - RAM data arrives at T+2.
  - tb_enable, tb_selection and the bank-select are delayed through a 2-stage pipeline so all three are valid at T+2.
  - tb_d0 = tb_d1 = rdata of the delayed read bank (combinational mux).
- tb_enable = 1 at T+2 iff RUN and acs_valid at T.
- Gap in RUN (acs_valid = 0):
  - No counter advance, we = 0.
  - tb_enable = 0 two cycles later.
  - err_gap sets and holds until reset or clear.
- Gap in FILL: pauses only; no error.
- First RUN cycle reads the bank filled during FILL, starting at address DEPTH-1.
- Mid-block reset or clear: abandon the block; the next start re-enters FILL. Pipeline registers clear, so tb_enable drops at once.
- Simultaneous clear and acs_valid: clear wins; the input is dropped.

Decomposition:
- Package tb_pkg:
  - typedef state_t {IDLE, FILL, RUN}.
  - constants DEPTH, AW, DW, RD_LAT = 2.
  - typedef bank_t (1 bit, A = 0, B = 1).
- Sub-module tb_align_pipe: parameterised-depth delay line for {enable, selection, bank}, with asynchronous reset and synchronous clear.

Test Plan (DEPTH = 8):
1. Reset, then 8 consecutive acs_valid with acs_dec = 0x00..0x07:
   - we_a = 1 at addr 0..7, with wdata matching;
   - we_b = 0;
   - tb_enable stays 0;
   - state becomes RUN after the 8th write.
2. Next 8 acs_valid:
   - writes go to bank B at addr 0..7;
   - addr_a = 7,6,...,0 with we_a = 0;
   - with rdata_a modelled, tb_d0 = 0x07,0x06,...,0x00 two cycles later;
   - tb_selection = 0,0,0,0,1,1,1,1;
   - tb_enable = 1 throughout.
3. Third block:
   - bank roles swap: write A, read B backwards;
   - tb_selection falls 1->0 exactly at the first entry of the block.
4. Drop acs_valid for 1 cycle mid-RUN:
   - addresses hold;
   - tb_enable = 0 for one aligned cycle;
   - err_gap = 1 and stays 1.
5. Assert clear mid-block with acs_valid = 1:
   - next cycle we = 0, tb_enable = 0, err_gap = 0, state IDLE;
   - 8 further writes are needed before tb_enable rises again.
6. Assert rst asynchronously mid-RUN (not on a clock edge):
   - all outputs go to 0 immediately;
   - after release, behaviour is identical to scenario 1.

Source files
------------

// File: rtl/tb_pkg.sv
// Shared types and constants for the traceback survivor-memory sequencer.
package tb_pkg;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
    typedef enum logic {BANK_A = 1'b0, BANK_B = 1'b1} bank_t;
endpackage

// File: rtl/tb_mem_ctrl_if.sv
// ACS input, ping-pong RAM bank and traceback-side signals of the survivor-memory sequencer.
interface tb_mem_ctrl_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          acs_valid;
    logic [DW-1:0] acs_dec;
    logic          we_a;
    logic          we_b;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata_a;
    logic [DW-1:0] rdata_b;
    logic [DW-1:0] tb_d0;
    logic [DW-1:0] tb_d1;
    logic          tb_enable;
    logic          tb_selection;
    logic          err_gap;

    modport slave (
        input  acs_valid, acs_dec, rdata_a, rdata_b,
        output we_a, we_b, addr_a, addr_b, wdata, tb_d0, tb_d1, tb_enable, tb_selection, err_gap
    );

    modport master (
        output acs_valid, acs_dec, rdata_a, rdata_b,
        input  we_a, we_b, addr_a, addr_b, wdata, tb_d0, tb_d1, tb_enable, tb_selection, err_gap
    );
endinterface

// File: rtl/tb_align_pipe.sv
// Delay line that lines traceback controls up with the RAM read data.
// Latency: STAGES cycles from din to dout.
// Backpressure: none; shifts every cycle, synchronous clear empties every stage.
module tb_align_pipe #(
    parameter int STAGES = 2,
    parameter int W      = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] pipe_q [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[STAGES-1];
endmodule

// File: rtl/tb_mem_ctrl.sv
// Survivor-memory sequencer: ping-pong writes of ACS decisions, backward reads of the other bank for traceback.
// Latency: RAM write controls 1 cycle after acs_valid; traceback enable/selection/data 2 cycles after.
// Backpressure: none; a cycle without acs_valid in RUN stalls the counters and sets sticky err_gap.
module tb_mem_ctrl
    import tb_pkg::*;
#(
    parameter int DEPTH = tb_pkg::DEPTH,
    parameter int AW    = tb_pkg::AW,
    parameter int DW    = tb_pkg::DW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    tb_mem_ctrl_if.slave bus
);
    state_t        state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr;
    bank_t         wr_bank_q, wr_bank_d, rd_bank, bank_out;
    logic          we_a_q, we_a_d, we_b_q, we_b_d;
    logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          en_in, sel_in;
    logic [2:0]    pipe_out;

    // Reading DEPTH-1-wr_addr walks the opposite bank backwards as this one fills.
    assign rd_addr = AW'(DEPTH - 1) - wr_addr_q;
    assign rd_bank = (wr_bank_q == BANK_A) ? BANK_B : BANK_A;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_bank_d = wr_bank_q;
        we_a_d    = 1'b0;
        we_b_d    = 1'b0;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        en_in     = 1'b0;
        // Lower half of the read block is the decode segment; it holds through gaps.
        sel_in    = (state_q == RUN) && !rd_addr[AW-1];

        if (clear) begin
            state_d   = IDLE;
            wr_addr_d = '0;
            wr_bank_d = BANK_A;
            addr_a_d  = '0;
            addr_b_d  = '0;
            wdata_d   = '0;
            err_d     = 1'b0;
        end else if (bus.acs_valid) begin
            wdata_d   = bus.acs_dec;
            wr_addr_d = wr_addr_q + AW'(1);
            if (wr_bank_q == BANK_A) begin
                we_a_d   = 1'b1;
                addr_a_d = wr_addr_q;
            end else begin
                we_b_d   = 1'b1;
                addr_b_d = wr_addr_q;
            end
            if (state_q == RUN) begin
                en_in = 1'b1;
                if (rd_bank == BANK_A) addr_a_d = rd_addr;
                else                   addr_b_d = rd_addr;
            end
            if (wr_addr_q == AW'(DEPTH - 1)) begin
                wr_bank_d = rd_bank;
                if (state_q == FILL) state_d = RUN;
            end
            if (state_q == IDLE) state_d = FILL;
        end else if (state_q == RUN) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_addr_q <= '0;
            wr_bank_q <= BANK_A;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_bank_q <= wr_bank_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    tb_align_pipe #(
        .STAGES (RD_LAT),
        .W      (3)
    ) u_align (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .din   ({en_in, sel_in, rd_bank}),
        .dout  (pipe_out)
    );

    assign bank_out         = bank_t'(pipe_out[0]);
    assign bus.tb_enable    = pipe_out[2];
    assign bus.tb_selection = pipe_out[1];
    assign bus.tb_d0        = pipe_out[2] ? ((bank_out == BANK_B) ? bus.rdata_b : bus.rdata_a) : '0;
    assign bus.tb_d1        = bus.tb_d0;
    assign bus.we_a         = we_a_q;
    assign bus.we_b         = we_b_q;
    assign bus.addr_a       = addr_a_q;
    assign bus.addr_b       = addr_b_q;
    assign bus.wdata        = wdata_q;
    assign bus.err_gap      = err_q;
endmodule

// File: tb/tb_tb_mem_ctrl.sv
// Bench for tb_mem_ctrl at DEPTH=8: table-driven blocks plus gap, clear and async-reset sequences,
// with write-side and traceback-side expectations queued per due cycle and compared as they fall due.
module tb_tb_mem_ctrl;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int DW    = 8;

    typedef struct packed {
        logic [31:0]   due;
        logic          we_a;
        logic          we_b;
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic          care_a;
        logic          care_b;
        logic [DW-1:0] wdata;
        logic          care_wd;
        logic          err;
    } wexp_t;

    typedef struct packed {
        logic [31:0]   due;
        logic          en;
        logic          sel;
        logic          care_sel;
        logic [DW-1:0] d;
        logic          care_d;
    } rexp_t;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] dec;
        wexp_t         w;
        rexp_t         r;
    } vec_t;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;
    int   cnt     = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    wexp_t wq[$];
    rexp_t rq[$];
    vec_t  tbl[24];

    logic [DW-1:0] ram_a [DEPTH];
    logic [DW-1:0] ram_b [DEPTH];

    tb_mem_ctrl_if #(.AW(AW), .DW(DW)) bus ();

    tb_mem_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cnt <= cnt + 1;

    // Two synchronous single-port RAM banks, one cycle read latency.
    always @(posedge clk) begin
        if (bus.we_a) ram_a[bus.addr_a] <= bus.wdata;
        if (bus.we_b) ram_b[bus.addr_b] <= bus.wdata;
        bus.rdata_a <= ram_a[bus.addr_a];
        bus.rdata_b <= ram_b[bus.addr_b];
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cnt, act, exp);
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_we_a"},   32'(bus.we_a),         0);
        chk({pfx, "_we_b"},   32'(bus.we_b),         0);
        chk({pfx, "_addr_a"}, 32'(bus.addr_a),       0);
        chk({pfx, "_addr_b"}, 32'(bus.addr_b),       0);
        chk({pfx, "_wdata"},  32'(bus.wdata),        0);
        chk({pfx, "_en"},     32'(bus.tb_enable),    0);
        chk({pfx, "_sel"},    32'(bus.tb_selection), 0);
        chk({pfx, "_d0"},     32'(bus.tb_d0),        0);
        chk({pfx, "_d1"},     32'(bus.tb_d1),        0);
        chk({pfx, "_err"},    32'(bus.err_gap),      0);
    endtask

    task automatic check_due();
        wexp_t w;
        rexp_t r;
        while (wq.size() > 0 && wq[0].due == cnt) begin
            w = wq.pop_front();
            chk("we_a", 32'(bus.we_a), 32'(w.we_a));
            chk("we_b", 32'(bus.we_b), 32'(w.we_b));
            if (w.care_a)  chk("addr_a", 32'(bus.addr_a), 32'(w.addr_a));
            if (w.care_b)  chk("addr_b", 32'(bus.addr_b), 32'(w.addr_b));
            if (w.care_wd) chk("wdata",  32'(bus.wdata),  32'(w.wdata));
            chk("err_gap", 32'(bus.err_gap), 32'(w.err));
        end
        while (rq.size() > 0 && rq[0].due == cnt) begin
            r = rq.pop_front();
            chk("tb_enable", 32'(bus.tb_enable), 32'(r.en));
            if (r.care_sel) chk("tb_selection", 32'(bus.tb_selection), 32'(r.sel));
            if (r.care_d) begin
                chk("tb_d0", 32'(bus.tb_d0), 32'(r.d));
                chk("tb_d1", 32'(bus.tb_d1), 32'(r.d));
            end
        end
    endtask

    // Block b, entry i: even blocks write bank A, odd write B; block b>0 reads block b-1 backwards.
    function automatic vec_t make_vec(input int b, input int i, input logic err);
        vec_t x;
        int   rd;
        x  = '0;
        rd = DEPTH - 1 - i;
        x.v = 1'b1;
        x.dec = DW'(b * 16 + i);
        x.w.care_a  = 1'b1;
        x.w.care_b  = 1'b1;
        x.w.care_wd = 1'b1;
        x.w.wdata   = x.dec;
        x.w.err     = err;
        if (b % 2 == 0) begin
            x.w.we_a   = 1'b1;
            x.w.addr_a = AW'(i);
            if (b == 0) x.w.addr_b = '0;
            else        x.w.addr_b = AW'(rd);
        end else begin
            x.w.we_b   = 1'b1;
            x.w.addr_b = AW'(i);
            x.w.addr_a = AW'(rd);
        end
        x.r.care_sel = 1'b1;
        x.r.care_d   = 1'b1;
        if (b > 0) begin
            x.r.en  = 1'b1;
            x.r.sel = (rd < DEPTH / 2);
            x.r.d   = DW'((b - 1) * 16 + rd);
        end
        return x;
    endfunction

    function automatic vec_t idle_vec(input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                                      input logic err, input logic care_r);
        vec_t x;
        x = '0;
        x.w.addr_a   = aa;
        x.w.addr_b   = ab;
        x.w.care_a   = 1'b1;
        x.w.care_b   = 1'b1;
        x.w.err      = err;
        x.r.care_sel = care_r;
        x.r.care_d   = care_r;
        return x;
    endfunction

    task automatic apply(input vec_t x, input logic clr);
        rexp_t z;
        @(negedge clk);
        check_due();
        bus.acs_valid = x.v;
        bus.acs_dec   = x.dec;
        clear         = clr;
        if (clr) begin
            // Clear flushes the alignment pipe, so anything still in flight reads back as idle.
            while (rq.size() > 0 && rq[$].due > cnt) void'(rq.pop_back());
            z = '0;
            z.due      = cnt + 1;
            z.care_sel = 1'b1;
            z.care_d   = 1'b1;
            rq.push_back(z);
        end
        x.w.due = cnt + 1;
        x.r.due = cnt + 2;
        wq.push_back(x.w);
        rq.push_back(x.r);
    endtask

    initial begin
        vec_t x;
        bus.acs_valid = 1'b0;
        bus.acs_dec   = '0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        for (int b = 0; b < 3; b++)
            for (int i = 0; i < DEPTH; i++)
                tbl[b * DEPTH + i] = make_vec(b, i, 1'b0);
        for (int k = 0; k < 24; k++) apply(tbl[k], 1'b0);

        // One-cycle gap in RUN.
        for (int i = 0; i < 3; i++) apply(make_vec(3, i, 1'b0), 1'b0);
        apply(idle_vec(AW'(5), AW'(2), 1'b1, 1'b0), 1'b0);
        for (int i = 3; i < DEPTH; i++) apply(make_vec(3, i, 1'b1), 1'b0);

        // Clear together with a valid input, then refill with a gap in FILL.
        for (int i = 0; i < 3; i++) apply(make_vec(4, i, 1'b1), 1'b0);
        x = idle_vec('0, '0, 1'b0, 1'b1);
        x.v = 1'b1;
        x.dec = 8'hEE;
        x.w.care_wd = 1'b1;
        apply(x, 1'b1);
        apply(idle_vec('0, '0, 1'b0, 1'b1), 1'b0);
        for (int i = 0; i < 4; i++) apply(make_vec(0, i, 1'b0), 1'b0);
        apply(idle_vec(AW'(3), '0, 1'b0, 1'b1), 1'b0);
        for (int i = 4; i < DEPTH; i++) apply(make_vec(0, i, 1'b0), 1'b0);
        for (int i = 0; i < 4; i++) apply(make_vec(1, i, 1'b0), 1'b0);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        check_due();
        bus.acs_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("arst");
        wq.delete();
        rq.delete();
        @(negedge clk);
        @(negedge clk);
        #3 rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) apply(make_vec(0, i, 1'b0), 1'b0);
        for (int i = 0; i < 2; i++) apply(make_vec(1, i, 1'b0), 1'b0);

        @(negedge clk);
        check_due();
        bus.acs_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_due();
        end
        chk("scoreboard_drained", 32'(wq.size() + rq.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
